rx_dispatch: RTL and testbench
==============================

// Module: rx_dispatch
// PURPOSE
// - Receive-side counterpart of the per-device TX buffer/arbiter: takes the decoded frame stream from ethernet_rx
//   (one-hot type, sop/eop/vld, byte, length) and steers each frame into a per-device store-and-forward buffer.
// - A device sees only whole, length-checked frames, delivered with a valid/ready handshake.
// - Sits between ethernet_rx and the ETH_NUM device ports.
// PARAMETERS
// - ETH_NUM     1     number of device channels; width of rx_type and of all per-device vectors
// - FIFO_DEPTH  2048  entries per channel buffer; power of 2, >= 2048
// - LEN_W       11    width of rx_len, in bytes
// PORTS
// - clk           in   1          single clock; all logic in this domain
// - rst_n         in   1          asynchronous active-low reset
// - rx_type       in   ETH_NUM    one-hot destination channel; sampled on the sop beat
// - rx_vld        in   1          byte valid; no backpressure to ethernet_rx
// - rx_sop        in   1          first byte of frame; qualified by rx_vld
// - rx_eop        in   1          last byte of frame; qualified by rx_vld
// - rx_data       in   8          frame byte
// - rx_len        in   LEN_W      payload length in bytes; valid on the sop beat
// - dev_rx_rdy    in   ETH_NUM    device ready, one bit per channel
// - dev_rx_vld    out  ETH_NUM    output byte valid, one bit per channel
// - dev_rx_sop    out  ETH_NUM    first byte of a delivered frame
// - dev_rx_eop    out  ETH_NUM    last byte of a delivered frame
// - dev_rx_data   out  ETH_NUM*8  output byte; channel i uses [i*8+:8]
// - drop_cnt      out  ETH_NUM*16 per-channel dropped-frame counters (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0; every buffer empty; write side idle; drop_cnt = 0.
// - Entry format: 10 bits {sop, eop, data[7:0]}.
// - Write FSM, one per channel: IDLE -> WR -> IDLE, or IDLE -> DROP -> IDLE.
//   - IDLE to WR on (rx_vld & rx_sop & rx_type[i]) when all hold: rx_type is one-hot; 1 <= rx_len <= free entries.
//   - Any other sop addressed to the channel goes to DROP. A non-one-hot rx_type drops the frame on every channel.
//   - WR: every beat writes at wr_ptr (a speculative pointer); a byte counter counts beats.
//     - Eop with count == rx_len: commit_ptr <= wr_ptr+1 in the same cycle, then go to IDLE.
//     - Eop with count != rx_len, or count reaching rx_len without eop: roll back (wr_ptr <= commit_ptr); go to IDLE on eop, otherwise to DROP.
//   - DROP: discard all beats; leave on eop.
//   - Sop while in WR or DROP: roll back the open frame, count one drop, then evaluate the new sop as if in IDLE (same cycle).
//   - Beats with rx_vld=1 outside any frame (no sop seen) are ignored.
// - Read side: sees only committed data, rd_ptr up to commit_ptr; registered output stage (first-word-fall-through).
//   - Earliest dev_rx_vld: 2 cycles after the eop beat is written.
//   - Transfer when dev_rx_vld & dev_rx_rdy; back-to-back transfers at 1 byte/cycle.
//   - With vld=1 and rdy=0, data/sop/eop hold stable; vld never drops without a transfer.
// - Pointers: $clog2(FIFO_DEPTH)+1 bits, wrap naturally.
//   - free = FIFO_DEPTH - (wr_ptr - rd_ptr).
//   - A buffer exactly full (free=0) accepts no frame; a frame with rx_len == free is accepted.
// - Reads and writes on one channel in the same cycle are legal; the admission check uses the current cycle's free count.
// - Async reset mid-frame discards all buffered and in-flight data.
// CONFIGURATION
// - RX_DROP_CNT_EN defined: drop_cnt[i*16+:16] increments once per dropped frame and saturates at 16'hFFFF.
//   - Drop causes: no space, length mismatch, sop abort, bad type.
// - RX_DROP_CNT_EN undefined: drop_cnt is tied to 0 and no counter registers exist. Drop behaviour is otherwise identical.
// STRUCTURE
// - rx_dispatch_pkg: ENTRY_W=10, SOP_BIT=9, EOP_BIT=8, and the write-FSM state enum (IDLE, WR, DROP).
// - Sub-module rx_pkt_buf, one per channel via generate: write FSM, commit/rollback pointers, simple dual-port RAM,
//   output register stage.
// - The top level keeps only the one-hot check and the fan-out of the input stream.
// TESTING
// - ETH_NUM=2, 64B frame type=2'b01, rdy=1 -> ch0 delivers 64 bytes, sop on byte 0, eop on byte 63, first vld 2 cycles after input eop; ch1 stays idle.
// - Length mismatch, rx_len=10 with eop on beat 8 -> no output; drop_cnt[0]=1; a following 10B frame is delivered intact.
// - Fill ch0 to free=100, send rx_len=101 -> dropped; then rx_len=100 -> accepted; free=0.
// - Sop on beat 20 of an open 40B frame -> first frame rolled back; second frame delivered; drop_cnt=1.
// - rx_type=2'b11 on sop -> frame dropped on both channels; no output on either.
// - Backpressure: toggle dev_rx_rdy every cycle over a 1500B frame -> 1500 bytes in order, stable while stalled.
//   - Also assert rst_n=0 mid-delivery -> all outputs 0 immediately and buffers empty.

Source files
------------

// File: rtl/rx_dispatch_pkg.sv
// rx_dispatch_pkg: buffer entry layout and write-FSM state encoding shared by rx_dispatch.
package rx_dispatch_pkg;
   localparam int ENTRY_W = 10;
   localparam int SOP_BIT = 9;
   localparam int EOP_BIT = 8;
   typedef enum logic [1:0] {IDLE, WR, DROP} wr_state_t;
endpackage

// File: rtl/rx_pkt_buf.sv
// rx_pkt_buf: per-channel store-and-forward frame buffer with speculative write, commit/rollback and FWFT output.
// Per-channel drop counter exists only when RX_DROP_CNT_EN is defined.
module rx_pkt_buf
   import rx_dispatch_pkg::*;
#(
   parameter int FIFO_DEPTH = 2048,
   parameter int LEN_W      = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sel,
   input  logic             bad_type,
   input  logic             rx_vld,
   input  logic             rx_sop,
   input  logic             rx_eop,
   input  logic [7:0]       rx_data,
   input  logic [LEN_W-1:0] rx_len,
   input  logic             dev_rdy,
   output logic             dev_vld,
   output logic             dev_sop,
   output logic             dev_eop,
   output logic [7:0]       dev_data,
   output logic [15:0]      drop_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

   wr_state_t state, state_n;
   logic [PW-1:0] wr_ptr, wr_ptr_n, commit_ptr, commit_n, rd_ptr, wr_addr, free;
   logic [LEN_W-1:0] cnt, cnt_n, len_q, cur_len, n;
   logic fits, start, reject, we, len_bad, load;
   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [ENTRY_W-1:0] out_q;

   // admission is judged against committed data only; the open frame is always discarded by a new sop
   assign free    = DEPTH_P - (commit_ptr - rd_ptr);
   assign fits    = (rx_len != '0) && ({{PW{1'b0}}, rx_len} <= {{LEN_W{1'b0}}, free});
   assign start   = rx_vld && rx_sop && sel && !bad_type && fits;
   assign reject  = rx_vld && rx_sop && (bad_type || (sel && !fits));
   assign we      = start || (rx_vld && !rx_sop && state == WR);
   assign cur_len = start ? rx_len : len_q;
   assign n       = start ? LEN_W'(1) : cnt + LEN_W'(1);
   assign wr_addr = start ? commit_ptr : wr_ptr;
   assign len_bad = we && ((n == cur_len) != rx_eop);

   always_comb begin
      state_n  = state;
      wr_ptr_n = wr_ptr;
      commit_n = commit_ptr;
      cnt_n    = cnt;
      if (rx_vld && rx_sop) begin
         wr_ptr_n = commit_ptr;
         state_n  = reject ? (rx_eop ? IDLE : DROP) : (start ? WR : IDLE);
      end else if (rx_vld && rx_eop && state == DROP)
         state_n = IDLE;
      if (we) begin
         cnt_n    = n;
         wr_ptr_n = len_bad ? commit_ptr : wr_addr + PW'(1);
         commit_n = (rx_eop && !len_bad) ? wr_addr + PW'(1) : commit_ptr;
         state_n  = rx_eop ? IDLE : (len_bad ? DROP : WR);
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         cnt        <= '0;
         len_q      <= '0;
      end else begin
         state      <= state_n;
         wr_ptr     <= wr_ptr_n;
         commit_ptr <= commit_n;
         cnt        <= cnt_n;
         len_q      <= cur_len;
      end

   always_ff @(posedge clk)
      if (we) mem[wr_addr[AW-1:0]] <= {rx_sop, rx_eop, rx_data};

   assign load = (rd_ptr != commit_ptr) && (!dev_vld || dev_rdy);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr  <= '0;
         dev_vld <= 1'b0;
         out_q   <= '0;
      end else begin
         dev_vld <= load || (dev_vld && !dev_rdy);
         if (load) begin
            rd_ptr <= rd_ptr + PW'(1);
            out_q  <= mem[rd_ptr[AW-1:0]];
         end
      end

   assign dev_sop  = out_q[SOP_BIT];
   assign dev_eop  = out_q[EOP_BIT];
   assign dev_data = out_q[7:0];

`ifdef RX_DROP_CNT_EN
   logic abort;
   logic [16:0] drop_sum;
   // an abort and the rejection of the new frame may land in the same cycle
   assign abort    = rx_vld && rx_sop && state == WR;
   assign drop_sum = {1'b0, drop_cnt} + 17'(abort) + 17'(reject || len_bad);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) drop_cnt <= '0;
      else drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`else
   assign drop_cnt = '0;
`endif
endmodule

// File: rtl/rx_dispatch.sv
// rx_dispatch: steers the decoded RX frame stream into per-device frame buffers.
// Optional per-channel drop counters enabled by RX_DROP_CNT_EN.
module rx_dispatch #(
   parameter int ETH_NUM    = 1,
   parameter int FIFO_DEPTH = 2048,
   parameter int LEN_W      = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ETH_NUM-1:0]    rx_type,
   input  logic                  rx_vld,
   input  logic                  rx_sop,
   input  logic                  rx_eop,
   input  logic [7:0]            rx_data,
   input  logic [LEN_W-1:0]      rx_len,
   input  logic [ETH_NUM-1:0]    dev_rx_rdy,
   output logic [ETH_NUM-1:0]    dev_rx_vld,
   output logic [ETH_NUM-1:0]    dev_rx_sop,
   output logic [ETH_NUM-1:0]    dev_rx_eop,
   output logic [ETH_NUM*8-1:0]  dev_rx_data,
   output logic [ETH_NUM*16-1:0] drop_cnt
);
   logic bad_type;

   assign bad_type = (rx_type == '0) || ((rx_type & (rx_type - ETH_NUM'(1))) != '0);

   genvar i;
   generate
      for (i = 0; i < ETH_NUM; i++) begin : g_ch
         rx_pkt_buf #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .LEN_W      (LEN_W)
         ) u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .sel      (rx_type[i]),
            .bad_type (bad_type),
            .rx_vld   (rx_vld),
            .rx_sop   (rx_sop),
            .rx_eop   (rx_eop),
            .rx_data  (rx_data),
            .rx_len   (rx_len),
            .dev_rdy  (dev_rx_rdy[i]),
            .dev_vld  (dev_rx_vld[i]),
            .dev_sop  (dev_rx_sop[i]),
            .dev_eop  (dev_rx_eop[i]),
            .dev_data (dev_rx_data[i*8+:8]),
            .drop_cnt (drop_cnt[i*16+:16])
         );
      end
   endgenerate
endmodule

// File: tb/tb_rx_dispatch.sv
// tb_rx_dispatch: table-driven, directed and randomized checks of rx_dispatch against a frame-level scoreboard.
module tb_rx_dispatch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  rx_type;
   logic        rx_vld, rx_sop, rx_eop;
   logic [7:0]  rx_data;
   logic [10:0] rx_len;
   logic [1:0]  dev_rx_rdy, dev_rx_vld, dev_rx_sop, dev_rx_eop;
   logic [15:0] dev_rx_data;
   logic [31:0] drop_cnt;

   int n_cmp = 0, n_bad = 0, cyc = 0, eop_cyc = 0, rdy_mode = 0;
   int got [2] = '{0, 0};
   int first_vld [2] = '{-1, -1};
   int exp_drop [2] = '{0, 0};
   logic [9:0] expq [2][$];
   logic [1:0] p_vld = '0, p_rdy = '0;
   logic [9:0] p_ent [2];

   typedef struct {
      logic [1:0] typ;
      int len;
      int beats;
      bit eop;
      int exp0;
      int exp1;
      int d0;
      int d1;
   } vec_t;
   vec_t tbl [9];

   rx_dispatch #(.ETH_NUM(2), .FIFO_DEPTH(2048), .LEN_W(11)) dut (
      .clk(clk), .rst_n(rst_n), .rx_type(rx_type), .rx_vld(rx_vld), .rx_sop(rx_sop),
      .rx_eop(rx_eop), .rx_data(rx_data), .rx_len(rx_len), .dev_rx_rdy(dev_rx_rdy),
      .dev_rx_vld(dev_rx_vld), .dev_rx_sop(dev_rx_sop), .dev_rx_eop(dev_rx_eop),
      .dev_rx_data(dev_rx_data), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // scoreboard: every transfer must match the next byte of a frame the spec says is delivered
   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         logic [9:0] ent, e;
         ent = {dev_rx_sop[c], dev_rx_eop[c], dev_rx_data[c*8+:8]};
         if (rst_n) begin
            if (p_vld[c] && !p_rdy[c]) begin
               check($sformatf("ch%0d_stall_vld", c), 64'(dev_rx_vld[c]), 64'd1);
               check($sformatf("ch%0d_stall_hold", c), 64'(ent), 64'(p_ent[c]));
            end
            if (dev_rx_vld[c] && first_vld[c] < 0) first_vld[c] = cyc;
            if (dev_rx_vld[c] && dev_rx_rdy[c]) begin
               got[c]++;
               if (expq[c].size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL ch%0d_unexpected: got entry 0x%0h expected no transfer", c, ent);
               end else begin
                  e = expq[c].pop_front();
                  check($sformatf("ch%0d_byte", c), 64'(ent), 64'(e));
               end
            end
         end
         p_vld[c] = rst_n && dev_rx_vld[c];
         p_rdy[c] = dev_rx_rdy[c];
         p_ent[c] = ent;
      end
   end

   initial begin
      dev_rx_rdy = 2'b11;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: dev_rx_rdy = 2'b11;
            1: dev_rx_rdy = 2'b00;
            2: dev_rx_rdy = ~dev_rx_rdy;
            default: dev_rx_rdy = 2'($urandom) | 2'($urandom);
         endcase
      end
   end

   task automatic beat(input logic [1:0] t, input logic s, input logic e, input logic [7:0] d, input logic [10:0] l);
      @(posedge clk);
      #1;
      rx_vld  = 1'b1;
      rx_type = t;
      rx_sop  = s;
      rx_eop  = e;
      rx_data = d;
      rx_len  = l;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         rx_vld  = 1'b0;
         rx_sop  = 1'b0;
         rx_eop  = 1'b0;
         rx_type = 2'($urandom);
         rx_data = 8'($urandom);
         rx_len  = 11'($urandom);
      end
   endtask

   task automatic send(input logic [1:0] t, input int len, input int beats, input bit eop, input int ch, input bit good);
      for (int b = 0; b < beats; b++) begin
         logic [7:0] d;
         logic s, e;
         d = 8'($urandom);
         s = (b == 0);
         e = eop && (b == beats - 1);
         beat(s ? t : 2'($urandom), s, e, d, s ? 11'(len) : 11'($urandom));
         if (good) expq[ch].push_back({s, e, d});
         if (e) eop_cyc = cyc;
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      repeat (3) @(negedge clk);
      while ((expq[0].size() != 0 || expq[1].size() != 0 || dev_rx_vld != 2'b00) && k < 10000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 10000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d/%0d bytes left expected 0", expq[0].size(), expq[1].size());
         expq[0].delete();
         expq[1].delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_drops();
      for (int c = 0; c < 2; c++)
`ifdef RX_DROP_CNT_EN
         check($sformatf("drop_cnt%0d", c), 64'(drop_cnt[c*16+:16]), 64'(exp_drop[c]));
`else
         check($sformatf("drop_cnt%0d", c), 64'(drop_cnt[c*16+:16]), 64'd0);
`endif
   endtask

   initial begin
      #5_000_000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got no end of test expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, g1, ch, len, kind, beats;
      logic [1:0] t;
      bit e, good;
      tbl[0] = '{2'b01, 64, 64, 1'b1, 64, 0, 0, 0};
      tbl[1] = '{2'b01, 10, 8, 1'b1, 0, 0, 1, 0};
      tbl[2] = '{2'b01, 10, 10, 1'b1, 10, 0, 0, 0};
      tbl[3] = '{2'b11, 12, 12, 1'b1, 0, 0, 1, 1};
      tbl[4] = '{2'b10, 5, 5, 1'b1, 0, 5, 0, 0};
      tbl[5] = '{2'b00, 5, 5, 1'b1, 0, 0, 1, 1};
      tbl[6] = '{2'b10, 0, 3, 1'b1, 0, 0, 0, 1};
      tbl[7] = '{2'b10, 4, 6, 1'b1, 0, 0, 0, 1};
      tbl[8] = '{2'b01, 1, 1, 1'b1, 1, 0, 0, 0};
      rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_type = '0; rx_data = '0; rx_len = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_vld", 64'(dev_rx_vld), 64'd0);
      check("rst_sop_eop", 64'({dev_rx_sop, dev_rx_eop}), 64'd0);
      check("rst_data", 64'(dev_rx_data), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         g0 = got[0];
         g1 = got[1];
         first_vld = '{-1, -1};
         send(tbl[i].typ, tbl[i].len, tbl[i].beats, tbl[i].eop, (tbl[i].typ == 2'b10) ? 1 : 0,
              (tbl[i].exp0 + tbl[i].exp1) > 0);
         idle(1);
         wait_idle();
         exp_drop[0] += tbl[i].d0;
         exp_drop[1] += tbl[i].d1;
         check($sformatf("vec%0d_ch0_bytes", i), 64'(got[0] - g0), 64'(tbl[i].exp0));
         check($sformatf("vec%0d_ch1_bytes", i), 64'(got[1] - g1), 64'(tbl[i].exp1));
         check_drops();
         if (i == 0) begin
            check("latency", 64'(first_vld[0] - eop_cyc), 64'd2);
            check("ch1_quiet", 64'(first_vld[1]), 64'(-1));
         end
      end

      // new sop in the middle of an open frame
      g0 = got[0];
      send(2'b01, 40, 20, 1'b0, 0, 1'b0);
      send(2'b01, 10, 10, 1'b1, 0, 1'b1);
      idle(1);
      wait_idle();
      exp_drop[0]++;
      check("abort_bytes", 64'(got[0] - g0), 64'd10);
      check_drops();

      // buffer boundary: 1948 stored + 1 in output stage leaves free = 100
      rdy_mode = 1;
      g0 = got[0];
      send(2'b01, 1949, 1949, 1'b1, 0, 1'b1);
      idle(4);
      check("fill_head_vld", 64'(dev_rx_vld[0]), 64'd1);
      send(2'b01, 101, 101, 1'b1, 0, 1'b0);
      exp_drop[0]++;
      send(2'b01, 100, 100, 1'b1, 0, 1'b1);
      send(2'b01, 1, 1, 1'b1, 0, 1'b0);
      exp_drop[0]++;
      idle(2);
      check_drops();
      rdy_mode = 0;
      wait_idle();
      check("fill_bytes", 64'(got[0] - g0), 64'd2049);

      rdy_mode = 2;
      g0 = got[0];
      send(2'b01, 1500, 1500, 1'b1, 0, 1'b1);
      idle(1);
      wait_idle();
      check("bp_bytes", 64'(got[0] - g0), 64'd1500);

      // async reset in the middle of delivery
      send(2'b10, 300, 300, 1'b1, 1, 1'b1);
      idle(1);
      repeat (40) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_vld", 64'(dev_rx_vld), 64'd0);
      check("arst_sop_eop", 64'({dev_rx_sop, dev_rx_eop}), 64'd0);
      check("arst_data", 64'(dev_rx_data), 64'd0);
      check("arst_drop", 64'(drop_cnt), 64'd0);
      expq[0].delete();
      expq[1].delete();
      exp_drop = '{0, 0};
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rdy_mode = 0;
      repeat (20) @(negedge clk);
      check("post_rst_empty", 64'(dev_rx_vld), 64'd0);
      g1 = got[1];
      send(2'b10, 7, 7, 1'b1, 1, 1'b1);
      idle(1);
      wait_idle();
      check("post_rst_bytes", 64'(got[1] - g1), 64'd7);

      rdy_mode = 3;
      for (int k = 0; k < 80; k++) begin
         ch = $urandom_range(0, 1);
         kind = $urandom_range(0, 6);
         len = $urandom_range(2, 40);
         t = (ch == 0) ? 2'b01 : 2'b10;
         beats = len;
         e = 1'b1;
         good = 1'b0;
         case (kind)
            3: begin beats = $urandom_range(1, len - 1); exp_drop[ch]++; end
            4: begin beats = len + $urandom_range(1, 3); exp_drop[ch]++; end
            5: begin t = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00; exp_drop[0]++; exp_drop[1]++; end
            6: begin beats = $urandom_range(1, len - 1); e = 1'b0; exp_drop[ch]++; end
            default: good = 1'b1;
         endcase
         send(t, len, beats, e, ch, good);
         if (kind != 6) begin
            if ($urandom_range(0, 3) == 0) beat(2'($urandom), 1'b0, 1'($urandom), 8'($urandom), 11'($urandom));
            idle($urandom_range(0, 3));
         end
      end
      send(2'b01, 5, 5, 1'b1, 0, 1'b1);
      idle(1);
      wait_idle();
      check_drops();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
